// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF-stage PC owner with one-outstanding-request imem fetch and redirect handling
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        FetchBusyF
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_READY, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] tgt;

    assign tgt            = PCTargetE & ~32'h3;
    assign PCF            = pc_q;
    assign PCPlus4F       = pc_q + 32'd4;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = state_q == S_REQ;
    assign InstrValidF    = state_q == S_READY;
    assign FetchBusyF     = ~InstrValidF;
    assign InstrF         = InstrValidF ? instr_q : NOP_INSTR;

    // next-state: redirect beats stall everywhere; a response owed to a stale PC is swallowed in DROP
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        target_d = target_q;
        case (state_q)
            S_REQ: begin
                if (PCSrcE && imem_req_ready) begin
                    target_d = tgt;
                    state_d  = S_DROP;
                end else if (PCSrcE) begin
                    pc_d = tgt;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE && imem_rsp_valid) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (PCSrcE) begin
                    target_d = tgt;
                    state_d  = S_DROP;
                end else if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (PCSrcE) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (!StallF) begin
                    pc_d    = PCPlus4F;
                    state_d = S_REQ;
                end
            end
            default: begin
                if (PCSrcE && imem_rsp_valid) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (PCSrcE) begin
                    target_d = tgt;
                end else if (imem_rsp_valid) begin
                    pc_d    = target_q;
                    state_d = S_REQ;
                end
            end
        endcase
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            target_q <= target_d;
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF-stage producer feeding the IF/ID pipeline register's PCF, PCPlus4F and InstrF inputs.
- Owns the PC register and a valid/ready request/response interface to instruction memory, with at most one outstanding request.
- Holds each fetched instruction in a one-entry buffer until the ID stage accepts it; applies branch/jump redirects from EX.
- Tells the hazard unit when no instruction is available (FetchBusyF), so a bubble is inserted.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, value driven on InstrF when the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- StallF  input  1  hazard unit stall; holds PC and buffer.
- PCSrcE  input  1  redirect request from EX (taken branch/jump).
- PCTargetE  input  32  redirect target; bits [1:0] forced to 0 internally.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  fetch address, equals PCF.
- imem_rsp_valid  input  1  response data valid (one cycle per request).
- imem_rsp_data  input  32  fetched instruction word.
- PCF  output  32  PC of the instruction currently presented.
- PCPlus4F  output  32  PCF + 4, mod 2^32.
- InstrF  output  32  buffered instruction, or NOP_INSTR when none is valid.
- InstrValidF  output  1  buffer holds a valid instruction for PCF.
- FetchBusyF  output  1  equals ~InstrValidF; hazard unit flushes ID when this is 1.

Behaviour:
- Reset (async) values: PCF=RESET_PC, PCPlus4F=RESET_PC+4, state=REQ, buffer invalid, InstrF=NOP_INSTR, InstrValidF=0, imem_req_valid=1 in the first cycle after reset deasserts. Pending target register=0.
- States and outputs:
  - REQ: imem_req_valid=1.
  - WAIT: request outstanding.
  - READY: buffer valid, InstrValidF=1.
  - DROP: outstanding response must be discarded.
- Transitions without redirect (PCSrcE=0):
  - REQ: if imem_req_ready=1, go to WAIT; otherwise stay.
  - WAIT: if imem_rsp_valid=1, capture imem_rsp_data into the buffer and go to READY. InstrValidF rises the cycle after the response.
  - READY: if StallF=0, the instruction is consumed at the edge: PCF <= PCPlus4F, buffer invalidated, go to REQ. If StallF=1, hold everything.
- Redirect (PCSrcE=1) has priority over StallF in every state:
  - REQ with ready=0: PCF <= target, stay in REQ. The request address changes; this is the only permitted change of a pending request.
  - REQ with ready=1: the request is accepted for the old PC; store the target, go to DROP.
  - WAIT, rsp_valid=0: store the target, go to DROP.
  - WAIT, rsp_valid=1: the response is discarded, PCF <= target, go to REQ.
  - READY: buffer invalidated, PCF <= target, go to REQ.
  - DROP: the pending target is overwritten (latest wins).
- DROP: on imem_rsp_valid=1, discard the data, PCF <= pending target, go to REQ. A redirect in the same cycle uses the new PCTargetE.
- The PC never advances while StallF=1 unless a redirect occurs.
- imem_req_addr=PCF at all times; imem_req_valid=1 only in REQ.
- PCPlus4F is computed combinationally from PCF; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- imem_rsp_valid outside WAIT/DROP is ignored; the bench checks this with an assertion.
- Reset asserted mid-transaction returns all state immediately to reset values; the response to an in-flight request is then ignored (state REQ).
- Peak throughput: one instruction per 3 cycles with single-cycle memory (REQ, WAIT, READY). Pipelined fetch is out of scope.

Test Plan:
- Reset, ready=1, 1-cycle rsp of 32'h00500093 -> req addr 0x0; InstrValidF=1 two cycles after acceptance; InstrF=0x00500093, PCF=0, PCPlus4F=4; next req addr 0x4.
- READY with StallF=1 for 3 cycles -> PCF, InstrF, InstrValidF unchanged; no request issued; StallF=0 -> next req addr 0x4.
- Redirect in WAIT: PCSrcE=1, PCTargetE=0x100 -> DROP; late rsp 0xDEADBEEF is not shown (InstrValidF stays 0); next req addr 0x100.
- Redirect in READY with StallF=1, PCTargetE=0x203 -> buffer dropped; req addr 0x200; InstrF=NOP_INSTR meanwhile.
- Back-to-back redirects in DROP (0x40 then 0x80) -> after rsp, req addr 0x80.
- Reset asserted while in WAIT -> PCF=RESET_PC and InstrValidF=0 asynchronously; a stale rsp arriving later is ignored; first request goes to RESET_PC.
